uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_hold.sv | 59 +++++
 rtl/uart_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter and the team receiver.
//   - UART_* localparams : default frame geometry
//   - tx_state_e         : transmitter FSM state encoding
//   - even_parity()      : even-parity bit over a data word (zero-extended)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 2;
  localparam int UART_PARITY_BIT = 1;
  localparam int UART_IDLE_BITS  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_GAP
  } tx_state_e;

  // Zero-extension adds no ones, so any word up to 32 bits gives the same
  // parity as reducing it at its native width.
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// -----------------------------------------------------------------------------
// uart_tx_hold
// One-entry holding register in front of the transmitter shift register.
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset
//   in_data    : word offered by the upstream
//   in_valid   : in_data valid
//   in_ready   : holding register empty (word accepted when valid & ready)
//   out_data   : held word
//   out_full   : holding register holds a word
//   out_take   : transmitter moves the held word into its shift register
// -----------------------------------------------------------------------------
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_full,
  input  logic                 out_take
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  // A take only happens while full and an accept only while empty, so the
  // two can never collide on one edge; the word is never overwritten.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (out_take) begin
      full_d = 1'b0;
    end
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready = !full_q;
  assign out_data = data_q;
  assign out_full = full_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, DATA_BITS data bits MSB first, optional even
// parity, STOP_BITS stop bits, then an inter-frame gap. One line bit per Clk.
// Ports:
//   Clk, Rst  : clock, synchronous active-high reset
//   Tx_Data   : word to send
//   Tx_Valid  : Tx_Data valid
//   Tx_Ready  : holding register empty
//   CTS       : clear-to-send, only sampled while idle
//   Tx_Break  : break request (only with UART_TX_BREAK_EN)
//   Tx_Out    : registered serial line, idle high
//   Tx_Busy   : FSM not idle
// Configuration macro: UART_TX_BREAK_EN adds the Tx_Break port and break
// frames (line held low for the length of a whole frame, then the gap).
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int STOP_BITS  = UART_STOP_BITS,
  parameter int PARITY_BIT = UART_PARITY_BIT,
  parameter int IDLE_BITS  = UART_IDLE_BITS
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_Valid,
  output logic                 Tx_Ready,
  input  logic                 CTS,
`ifdef UART_TX_BREAK_EN
  input  logic                 Tx_Break,
`endif
  output logic                 Tx_Out,
  output logic                 Tx_Busy
);

  // The IDLE cycle that samples CTS is itself a line-high cycle, so GAP only
  // supplies the remaining IDLE_BITS-1 cycles of the minimum spacing.
  localparam int GAP_CYCLES = IDLE_BITS - 1;
  localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int CNT_MAX_A  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_MAX    = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_out_q, tx_out_d;

  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 hold_take;

`ifdef UART_TX_BREAK_EN
  logic brk_q, brk_d;
`endif

  uart_tx_hold #(
    .DATA_BITS (DATA_BITS)
  ) u_hold (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_data  (Tx_Data),
    .in_valid (Tx_Valid),
    .in_ready (Tx_Ready),
    .out_data (hold_data),
    .out_full (hold_full),
    .out_take (hold_take)
  );

  // Next-state logic. Counters count down to zero so each state's length is
  // loaded once on entry. The line value is derived from the next state so
  // that the registered Tx_Out changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    hold_take = 1'b0;
    tx_out_d  = 1'b1;
`ifdef UART_TX_BREAK_EN
    brk_d     = brk_q;
`endif

    unique case (state_q)
      TX_IDLE: begin
`ifdef UART_TX_BREAK_EN
        // Break wins over a pending word; the held word stays for later.
        if (CTS && Tx_Break) begin
          state_d = TX_START;
          brk_d   = 1'b1;
          cnt_d   = '0;
        end else
`endif
        if (CTS && hold_full) begin
          state_d   = TX_START;
          hold_take = 1'b1;
          shift_d   = hold_data;
          par_d     = even_parity(32'(hold_data));
          cnt_d     = '0;
        end
      end

      TX_START: begin
        state_d = TX_DATA;
        cnt_d   = CNT_W'(DATA_BITS - 1);
      end

      TX_DATA: begin
        if (cnt_q == '0) begin
          if (PARITY_BIT != 0) begin
            state_d = TX_PARITY;
            cnt_d   = '0;
          end else begin
            state_d = TX_STOP;
            cnt_d   = CNT_W'(STOP_BITS - 1);
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          shift_d = shift_q << 1;
        end
      end

      TX_PARITY: begin
        state_d = TX_STOP;
        cnt_d   = CNT_W'(STOP_BITS - 1);
      end

      TX_STOP: begin
        if (cnt_q == '0) begin
`ifdef UART_TX_BREAK_EN
          brk_d = 1'b0;
`endif
          if (GAP_CYCLES > 0) begin
            state_d = TX_GAP;
            cnt_d   = CNT_W'(GAP_LAST);
          end else begin
            state_d = TX_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      TX_GAP: begin
        if (cnt_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase

    unique case (state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = shift_d[DATA_BITS-1];
      TX_PARITY: tx_out_d = par_d;
      default:   tx_out_d = 1'b1;
    endcase

`ifdef UART_TX_BREAK_EN
    // A break reuses the frame timing but forces every bit low.
    if (brk_d && (state_d inside {TX_START, TX_DATA, TX_PARITY, TX_STOP})) begin
      tx_out_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
`ifdef UART_TX_BREAK_EN
      brk_q    <= brk_d;
`endif
    end
  end

  assign Tx_Out  = tx_out_q;
  assign Tx_Busy = (state_q != TX_IDLE);

endmodule
